// File: rtl/malzeme_dagitici_if.sv
// malzeme_dagitici_if: request and dispense handshake bundle for the ingredient dispenser
interface malzeme_dagitici_if;
  logic       bitti;
  logic       secilen_malzeme;
  logic [3:0] malzeme_miktari;
  logic       cikis_tuzlu;
  logic       dagit_onay;
  logic       hazir;
  logic       dagit_gecerli;
  logic       dagit_malzeme;
  logic [3:0] kalan;
  logic       tamam;
  logic       reddedildi;
  logic       hata;
  modport slave (
    input  bitti, secilen_malzeme, malzeme_miktari, cikis_tuzlu, dagit_onay,
    output hazir, dagit_gecerli, dagit_malzeme, kalan, tamam, reddedildi, hata
  );
  modport master (
    output bitti, secilen_malzeme, malzeme_miktari, cikis_tuzlu, dagit_onay,
    input  hazir, dagit_gecerli, dagit_malzeme, kalan, tamam, reddedildi, hata
  );
endinterface

// File: rtl/malzeme_dagitici.sv
// malzeme_dagitici: dispenses a requested number of ingredient units with idle gaps and an ack timeout
module malzeme_dagitici #(
  parameter int ARA         = 2,
  parameter int ZAMAN_ASIMI = 8
) (
  input logic             saat,
  input logic             reset,
  malzeme_dagitici_if.slave bus
);
  typedef enum logic [1:0] {BOS, DAGIT, ARA_BEKLE, SON} durum_t;
  durum_t     durum;
  logic [3:0] ara_say;
  logic [3:0] bekle_say;
  // control FSM with every output registered alongside the state
  always_ff @(posedge saat) begin
    if (reset) begin
      durum             <= BOS;
      ara_say           <= '0;
      bekle_say         <= '0;
      bus.hazir         <= 1'b1;
      bus.dagit_gecerli <= 1'b0;
      bus.dagit_malzeme <= 1'b0;
      bus.kalan         <= '0;
      bus.tamam         <= 1'b0;
      bus.reddedildi    <= 1'b0;
      bus.hata          <= 1'b0;
    end else begin
      bus.tamam      <= 1'b0;
      bus.reddedildi <= 1'b0;
      case (durum)
        BOS: if (bus.bitti) begin
          if (bus.cikis_tuzlu) begin
            bus.reddedildi <= 1'b1;
            bus.kalan      <= '0;
          end else if (bus.malzeme_miktari == 4'd0) begin
            bus.tamam <= 1'b1;
            bus.kalan <= '0;
          end else begin
            durum             <= DAGIT;
            bus.kalan         <= bus.malzeme_miktari;
            bus.dagit_malzeme <= bus.secilen_malzeme;
            bus.dagit_gecerli <= 1'b1;
            bus.hazir         <= 1'b0;
            bekle_say         <= '0;
          end
        end
        DAGIT: if (bus.dagit_onay) begin
          bus.kalan         <= bus.kalan - 4'd1;
          bus.dagit_gecerli <= 1'b0;
          ara_say           <= '0;
          if (bus.kalan == 4'd1) begin
            durum     <= SON;
            bus.tamam <= 1'b1;
          end else begin
            durum <= ARA_BEKLE;
          end
        end else if (bekle_say == 4'(ZAMAN_ASIMI - 1)) begin
          durum             <= BOS;
          bus.hata          <= 1'b1;
          bus.dagit_gecerli <= 1'b0;
          bus.hazir         <= 1'b1;
        end else begin
          bekle_say <= bekle_say + 4'd1;
        end
        ARA_BEKLE: if (ara_say == 4'(ARA - 1)) begin
          durum             <= DAGIT;
          bus.dagit_gecerli <= 1'b1;
          bekle_say         <= '0;
        end else begin
          ara_say <= ara_say + 4'd1;
        end
        SON: begin
          durum     <= BOS;
          bus.hazir <= 1'b1;
        end
        default: durum <= BOS;
      endcase
    end
  end
endmodule
